flappy_game_core: RTL

//  Parametrised game/pixel core for the VGA Flappy pipeline: owns bird physics, game-state FSM,
//  per-pipe scoring, pixel-accurate collision and the pixel colour mux for NUM_PIPES pipes.

---
 rtl/flappy_game_core.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/flappy_game_core.sv
// Game/pixel core for the VGA Flappy pipeline: bird physics, game-state FSM, per-pipe scoring,
// pixel-accurate collision and the registered pixel colour mux for NUM_PIPES pipes.
module flappy_game_core #(
    parameter int NUM_PIPES   = 2,
    parameter int PIPE_HALF_W = 50,
    parameter int GAP_H       = 100,
    parameter int BIRD_X      = 300,
    parameter int BIRD_SZ     = 20,
    parameter int TICK_DIV    = 500000,
    parameter int FLAP_VEL    = 6,
    parameter int VEL_MAX     = 8,
    parameter int Y_TOP       = 35,
    parameter int Y_BOT       = 515,
    parameter int SCORE_W     = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    bright,
    input  logic [9:0]              hCount,
    input  logic [9:0]              vCount,
    input  logic                    button,
    input  logic [10*NUM_PIPES-1:0] pipe_x,
    input  logic [10*NUM_PIPES-1:0] pipe_gap_y,
    output logic [11:0]             rgb,
    output logic [SCORE_W-1:0]      score,
    output logic [1:0]              game_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DEAD = 2'd2
    } state_t;

    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(NUM_PIPES + 1);

    localparam logic [9:0]         Y_RST     = 10'((Y_TOP + Y_BOT) / 2 - BIRD_SZ / 2);
    localparam logic [9:0]         Y_TOP_V   = 10'(Y_TOP);
    localparam logic [9:0]         Y_LOW_V   = 10'(Y_BOT - BIRD_SZ);
    localparam logic signed [11:0] Y_MIN_S   = 12'(Y_TOP);
    localparam logic signed [11:0] Y_MAX_S   = 12'(Y_BOT - BIRD_SZ);
    localparam logic signed [5:0]  FLAP_S    = 6'(-FLAP_VEL);
    localparam logic signed [5:0]  VEL_MAX_S = 6'(VEL_MAX);

    localparam logic [11:0] COL_OFF  = 12'h000;
    localparam logic [11:0] COL_BIRD = 12'hFF0;
    localparam logic [11:0] COL_PIPE = 12'h0F0;
    localparam logic [11:0] COL_SKY  = 12'h08F;
    localparam logic [11:0] COL_DEAD = 12'hF00;

    state_t              state_r;
    logic [TW-1:0]       tick_cnt_r;
    logic                btn_q_r;
    logic                flap_pend_r;
    logic                hit_r;
    logic [9:0]          bird_y_r;
    logic signed [5:0]   vel_r;
    logic [SCORE_W-1:0]  score_r;
    logic [11:0]         rgb_r;
    logic [10:0]         prev_r [NUM_PIPES];

    logic                tick_s;
    logic                flap_s;
    logic [10:0]         h11_s;
    logic [10:0]         v11_s;
    logic [10:0]         by11_s;
    logic                in_bird_s;
    logic                in_pipe_s;
    logic [NUM_PIPES-1:0] pipe_px_s;
    logic [NUM_PIPES-1:0] cross_s;
    logic [10:0]         right_edge_s [NUM_PIPES];
    logic [CW-1:0]       cross_cnt_s;
    logic [SCORE_W:0]    score_sum_s;
    logic [SCORE_W-1:0]  score_next_s;
    logic signed [5:0]   vel_new_s;
    logic signed [11:0]  y_sum_s;
    logic [9:0]          y_next_s;
    logic                die_s;
    logic [11:0]         rgb_next_s;

    assign tick_s = (tick_cnt_r == TW'(TICK_DIV - 1));
    assign flap_s = button & ~btn_q_r;

    assign h11_s  = {1'b0, hCount};
    assign v11_s  = {1'b0, vCount};
    assign by11_s = {1'b0, bird_y_r};

    assign in_bird_s = (h11_s >= 11'(BIRD_X)) && (h11_s < 11'(BIRD_X + BIRD_SZ)) &&
                       (v11_s >= by11_s) && (v11_s < by11_s + 11'(BIRD_SZ));

    // Per-pipe extents; left edge clamps at column 0 instead of wrapping.
    for (genvar i = 0; i < NUM_PIPES; i++) begin : g_pipe
        logic [10:0] px_s;
        logic [10:0] gy_s;
        logic [10:0] left_s;
        logic [10:0] right_s;
        assign px_s    = {1'b0, pipe_x[10*i +: 10]};
        assign gy_s    = {1'b0, pipe_gap_y[10*i +: 10]};
        assign right_s = px_s + 11'(PIPE_HALF_W);
        assign left_s  = (px_s >= 11'(PIPE_HALF_W)) ? (px_s - 11'(PIPE_HALF_W)) : 11'd0;
        assign pipe_px_s[i] = (h11_s >= left_s) && (h11_s <= right_s) &&
                              ((v11_s < gy_s) || (v11_s >= gy_s + 11'(GAP_H)));
        assign right_edge_s[i] = right_s;
        assign cross_s[i] = (prev_r[i] >= 11'(BIRD_X)) && (right_s < 11'(BIRD_X));
    end

    assign in_pipe_s = |pipe_px_s;

    // Saturating score increment by the number of pipes that passed the bird this tick.
    always_comb begin
        cross_cnt_s = '0;
        for (int i = 0; i < NUM_PIPES; i++) begin
            cross_cnt_s = cross_cnt_s + CW'(cross_s[i]);
        end
        score_sum_s = {1'b0, score_r} + (SCORE_W + 1)'(cross_cnt_s);
        if (score_sum_s[SCORE_W]) begin
            score_next_s = '1;
        end else begin
            score_next_s = score_sum_s[SCORE_W-1:0];
        end
    end

    // Next velocity and clamped position applied when the bird survives a tick.
    always_comb begin
        if (flap_pend_r | flap_s) begin
            vel_new_s = FLAP_S;
        end else if (vel_r >= VEL_MAX_S) begin
            vel_new_s = VEL_MAX_S;
        end else begin
            vel_new_s = vel_r + 6'sd1;
        end
        y_sum_s = $signed({2'b00, bird_y_r}) + $signed({{6{vel_new_s[5]}}, vel_new_s});
        if (y_sum_s < Y_MIN_S) begin
            y_next_s = Y_TOP_V;
        end else if (y_sum_s > Y_MAX_S) begin
            y_next_s = Y_LOW_V;
        end else begin
            y_next_s = y_sum_s[9:0];
        end
    end

    assign die_s = hit_r || (by11_s + 11'(BIRD_SZ) >= 11'(Y_BOT)) || (bird_y_r <= Y_TOP_V);

    // Pixel colour: bird over pipe over background; background turns red once dead.
    always_comb begin
        if (!bright) begin
            rgb_next_s = COL_OFF;
        end else if (in_bird_s) begin
            rgb_next_s = COL_BIRD;
        end else if (in_pipe_s) begin
            rgb_next_s = COL_PIPE;
        end else if (state_r == ST_DEAD) begin
            rgb_next_s = COL_DEAD;
        end else begin
            rgb_next_s = COL_SKY;
        end
    end

    // Physics tick divider, button edge history, pixel output and per-pipe edge history.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tick_cnt_r <= '0;
            btn_q_r    <= 1'b0;
            rgb_r      <= COL_OFF;
            for (int i = 0; i < NUM_PIPES; i++) begin
                prev_r[i] <= 11'd0;
            end
        end else begin
            tick_cnt_r <= tick_s ? '0 : tick_cnt_r + TW'(1);
            btn_q_r    <= button;
            rgb_r      <= rgb_next_s;
            if (tick_s) begin
                for (int i = 0; i < NUM_PIPES; i++) begin
                    prev_r[i] <= right_edge_s[i];
                end
            end
        end
    end

    // Game FSM with bird motion, sticky collision and scoring.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            bird_y_r    <= Y_RST;
            vel_r       <= 6'sd0;
            score_r     <= '0;
            hit_r       <= 1'b0;
            flap_pend_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (flap_s) begin
                        state_r     <= ST_PLAY;
                        vel_r       <= FLAP_S;
                        score_r     <= '0;
                        hit_r       <= 1'b0;
                        flap_pend_r <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (bright && in_bird_s && in_pipe_s) begin
                        hit_r <= 1'b1;
                    end
                    if (tick_s) begin
                        flap_pend_r <= 1'b0;
                        score_r     <= score_next_s;
                        if (die_s) begin
                            state_r <= ST_DEAD;
                            vel_r   <= 6'sd0;
                        end else begin
                            vel_r    <= vel_new_s;
                            bird_y_r <= y_next_s;
                        end
                    end else if (flap_s) begin
                        flap_pend_r <= 1'b1;
                    end
                end
                ST_DEAD: begin
                    flap_pend_r <= 1'b0;
                    if (flap_s) begin
                        state_r  <= ST_IDLE;
                        bird_y_r <= Y_RST;
                        vel_r    <= 6'sd0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign rgb        = rgb_r;
    assign score      = score_r;
    assign game_state = state_r;

endmodule
